// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC hamming-weight accumulator.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_EMIT
  } accum_state_t;

  // Position of the sticky overrange flag inside the status byte.
  localparam int OVR_BIT = 0;

  // Number of whole bytes needed to carry a value of the given width.
  function automatic int sum_bytes(input int sum_w);
    return (sum_w + 7) / 8;
  endfunction

endpackage

// File: rtl/tdc_hw_accum_if.sv
// Byte-stream valid/ready port carrying the accumulator result packet.
interface tdc_hw_accum_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/tdc_byte_ser.sv
// Loads a packed packet (byte 0 in the LSBs) and streams it out one byte per
// handshake, flagging the final byte with out_last.
module tdc_byte_ser #(
  parameter int NBYTES = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                load_i,
  input  logic [NBYTES*8-1:0] pkt_i,
  output logic                active_o,
  output logic                done_o,
  tdc_hw_accum_if.master      out
);
  localparam int              IDX_W    = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NBYTES*8-1:0] pkt_q, pkt_d;
  logic                is_last;
  logic                xfer;

  assign is_last = valid_q && (idx_q == LAST_IDX);
  assign xfer    = valid_q && out.out_ready && en_i;

  // Load a fresh packet when idle, otherwise shift one byte out per transfer.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q;
    if (en_i) begin
      if (load_i && !valid_q) begin
        valid_d = 1'b1;
        idx_d   = '0;
        pkt_d   = pkt_i;
      end else if (xfer) begin
        pkt_d = pkt_q >> 8;
        if (is_last) begin
          valid_d = 1'b0;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_data  = valid_q ? pkt_q[7:0] : 8'h00;
  assign out.out_last  = is_last;
  assign active_o      = valid_q;
  assign done_o        = xfer && is_last;

endmodule

// File: rtl/tdc_hw_accum.sv
// Collects 2**LOG_SAMPLES hamming-weight samples per run, tracks min/max/sum
// and an overrange flag, then hands the result packet to the byte serializer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; stats hold the last run's values
//   ST_ACCUM | accepting samples until the final one of the run
//   ST_EMIT  | packet loaded into serializer, waiting for last byte
module tdc_hw_accum
  import tdc_pkg::*;
#(
  parameter int N           = 64,
  parameter int HW_W        = $clog2(N) + 1,
  parameter int LOG_SAMPLES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            start,
  input  logic            hw_valid,
  input  logic [HW_W-1:0] hw,
  output logic            busy,
  tdc_hw_accum_if.master  out
);
  localparam int              SUM_W     = HW_W + LOG_SAMPLES;
  localparam int              SUM_BYTES = sum_bytes(SUM_W);
  localparam int              PKT_BYTES = 4 + SUM_BYTES;
  localparam logic [HW_W-1:0] N_HW      = HW_W'(N);

  accum_state_t           state_q, state_d;
  logic [HW_W-1:0]        min_q, min_d;
  logic [HW_W-1:0]        max_q, max_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [LOG_SAMPLES-1:0] cnt_q, cnt_d;
  logic                   ovr_q, ovr_d;
  logic [HW_W-1:0]        hw_clamp;
  logic [HW_W-1:0]        mean;
  logic [7:0]             status_b;
  logic [PKT_BYTES*8-1:0] pkt;
  logic                   ser_load;
  logic                   ser_active;
  logic                   ser_done;

  assign hw_clamp = (hw > N_HW) ? N_HW : hw;
  // Sum is sized so the shifted mean always fits back into HW_W.
  assign mean     = HW_W'(sum_q >> LOG_SAMPLES);
  assign status_b = 8'(ovr_q) << OVR_BIT;
  assign pkt      = {(SUM_BYTES*8)'(sum_q), 8'(mean), 8'(max_q), 8'(min_q), status_b};
  assign busy     = (state_q != ST_IDLE);

  // Next state, sample accumulation and packet load; en low holds everything.
  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    max_d    = max_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    ser_load = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_ACCUM;
            min_d   = '1;
            max_d   = '0;
            sum_d   = '0;
            cnt_d   = '0;
            ovr_d   = 1'b0;
          end
        end
        ST_ACCUM: begin
          if (hw_valid) begin
            if (hw > N_HW) ovr_d = 1'b1;
            if (hw_clamp < min_q) min_d = hw_clamp;
            if (hw_clamp > max_q) max_d = hw_clamp;
            sum_d = sum_q + SUM_W'(hw_clamp);
            cnt_d = cnt_q + LOG_SAMPLES'(1);
            if (&cnt_q) state_d = ST_EMIT;
          end
        end
        ST_EMIT: begin
          ser_load = !ser_active;
          if (ser_done) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM and datapath registers; reset aborts any run in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      min_q   <= '1;
      max_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  tdc_byte_ser #(
    .NBYTES (PKT_BYTES)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (en),
    .load_i   (ser_load),
    .pkt_i    (pkt),
    .active_o (ser_active),
    .done_o   (ser_done),
    .out      (out)
  );

endmodule
